// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - host byte loader feeding a 16-word CPU memory; MEM_LOADER_WPROTECT_EN guards the loaded image
// The CPU is held in reset while the host streams the program; afterwards the CPU owns the memory.
module mem_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_clr,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] memoryIn,
  output logic [DATA_W-1:0] memoryOut,
  output logic [ADDR_W:0]   prog_len,
  output logic              wp_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {LOAD, RUN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic              load_ready_q;
  logic              cpu_clr_q;
  logic              wp_err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic accept;
  logic last_beat;
  logic wp_hit;
  logic unused_read;

  // The read strobe carries no meaning here: reads are combinational.
  assign unused_read = read;

  assign accept     = (state_q == LOAD) && load_valid;
  assign last_beat  = load_last || (&ptr_q);
  assign ptr_d      = ptr_q + 1'b1;
  assign prog_len_d = prog_len_q + 1'b1;

`ifdef MEM_LOADER_WPROTECT_EN
  assign wp_hit = ({1'b0, address} < prog_len_q);
`else
  assign wp_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= LOAD;
      ptr_q        <= '0;
      prog_len_q   <= '0;
      load_ready_q <= 1'b1;
      cpu_clr_q    <= 1'b1;
      wp_err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wp_err_q <= 1'b0;
      case (state_q)
        LOAD: begin
          if (accept) begin
            mem_q[ptr_q] <= load_data;
            ptr_q        <= ptr_d;
            prog_len_q   <= prog_len_d;
            // Leaving LOAD is one-way; a full memory ends loading even without load_last.
            if (last_beat) begin
              state_q      <= RUN;
              load_ready_q <= 1'b0;
              cpu_clr_q    <= 1'b0;
            end
          end
        end
        RUN: begin
          if (write) begin
            if (wp_hit) begin
              wp_err_q <= 1'b1;
            end else begin
              mem_q[address] <= memoryIn;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  always_comb begin
    memoryOut = '0;
    if (state_q == RUN) begin
      memoryOut = mem_q[address];
    end
  end

  assign load_ready = load_ready_q;
  assign cpu_clr    = cpu_clr_q;
  assign prog_len   = prog_len_q;
  assign wp_err     = wp_err_q;

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - directed self-checking bench for mem_loader (honours MEM_LOADER_WPROTECT_EN)
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       cpu_clr;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [3:0] address = 4'h0;
  logic [7:0] memoryIn = 8'h00;
  logic [7:0] memoryOut;
  logic [4:0] prog_len;
  logic       wp_err;

  int checks = 0;
  int errors = 0;

  mem_loader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .cpu_clr    (cpu_clr),
    .read       (read),
    .write      (write),
    .address    (address),
    .memoryIn   (memoryIn),
    .memoryOut  (memoryOut),
    .prog_len   (prog_len),
    .wp_err     (wp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    checks++;
    if ({load_ready, cpu_clr, memoryOut, prog_len, wp_err} !== {1'b1, 1'b1, 8'h00, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b cclr=%b out=%h len=%0d wp=%b want 1 1 00 0 0",
               load_ready, cpu_clr, memoryOut, prog_len, wp_err);
    end
  endtask

  task automatic test_load_last();
    logic [7:0] prog [8];
    prog = '{8'h45, 8'hA7, 8'h54, 8'h54, 8'h00, 8'h05, 8'h00, 8'h03};
    do_reset();
    for (int i = 0; i < 7; i++) send_byte(prog[i], 1'b0);
    checks++;
    if (cpu_clr !== 1'b1 || memoryOut !== 8'h00) begin
      errors++;
      $display("FAIL load_hold got cclr=%b out=%h want 1 00", cpu_clr, memoryOut);
    end
    send_byte(prog[7], 1'b1);
    checks++;
    if (prog_len !== 5'd8) begin
      errors++;
      $display("FAIL last_prog_len got %0d want 8", prog_len);
    end
    checks++;
    if (cpu_clr !== 1'b0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL last_run_entry got cclr=%b rdy=%b want 0 0", cpu_clr, load_ready);
    end
    address = 4'h1;
    #1;
    checks++;
    if (memoryOut !== 8'hA7) begin
      errors++;
      $display("FAIL read_addr1 got %h want a7", memoryOut);
    end
    address = 4'h9;
    #1;
    checks++;
    if (memoryOut !== 8'h00) begin
      errors++;
      $display("FAIL read_addr9 got %h want 00", memoryOut);
    end
    address = 4'h7;
    #1;
    checks++;
    if (memoryOut !== 8'h03) begin
      errors++;
      $display("FAIL read_addr7 got %h want 03", memoryOut);
    end
  endtask

  task automatic test_cpu_write();
    address  = 4'hC;
    memoryIn = 8'hAE;
    write    = 1'b1;
    #1;
    checks++;
    if (memoryOut !== 8'h00) begin
      errors++;
      $display("FAIL write_same_cycle_read got %h want 00", memoryOut);
    end
    tick();
    write = 1'b0;
    checks++;
    if (memoryOut !== 8'hAE) begin
      errors++;
      $display("FAIL write_next_cycle_read got %h want ae", memoryOut);
    end
  endtask

  task automatic test_wprotect();
    logic [7:0] exp_mem;
    logic       exp_wp;
`ifdef MEM_LOADER_WPROTECT_EN
    exp_mem = 8'h00;
    exp_wp  = 1'b1;
`else
    exp_mem = 8'hAE;
    exp_wp  = 1'b0;
`endif
    address  = 4'h4;
    memoryIn = 8'hAE;
    write    = 1'b1;
    tick();
    write = 1'b0;
    checks++;
    if (memoryOut !== exp_mem) begin
      errors++;
      $display("FAIL wp_mem4 got %h want %h", memoryOut, exp_mem);
    end
    checks++;
    if (wp_err !== exp_wp) begin
      errors++;
      $display("FAIL wp_err_pulse got %b want %b", wp_err, exp_wp);
    end
    tick();
    checks++;
    if (wp_err !== 1'b0) begin
      errors++;
      $display("FAIL wp_err_clear got %b want 0", wp_err);
    end
  endtask

  task automatic test_full16();
    do_reset();
    for (int i = 0; i < 15; i++) send_byte(8'h10 + 8'(i), 1'b0);
    checks++;
    if (load_ready !== 1'b1 || prog_len !== 5'd15) begin
      errors++;
      $display("FAIL full_pre16 got rdy=%b len=%0d want 1 15", load_ready, prog_len);
    end
    send_byte(8'h1F, 1'b0);
    checks++;
    if (load_ready !== 1'b0 || cpu_clr !== 1'b0 || prog_len !== 5'd16) begin
      errors++;
      $display("FAIL full_run got rdy=%b cclr=%b len=%0d want 0 0 16", load_ready, cpu_clr, prog_len);
    end
    send_byte(8'hFF, 1'b1);
    address = 4'h0;
    #1;
    checks++;
    if (prog_len !== 5'd16 || memoryOut !== 8'h10) begin
      errors++;
      $display("FAIL full_17th_ignored got len=%0d mem0=%h want 16 10", prog_len, memoryOut);
    end
    address = 4'hF;
    #1;
    checks++;
    if (memoryOut !== 8'h1F) begin
      errors++;
      $display("FAIL full_addr15 got %h want 1f", memoryOut);
    end
  endtask

  task automatic test_clr_midload();
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    // CPU writes during LOAD must be ignored
    address  = 4'h5;
    memoryIn = 8'h55;
    write    = 1'b1;
    send_byte(8'h33, 1'b0);
    write = 1'b0;
    clr        = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h77;
    tick();
    clr        = 1'b0;
    load_valid = 1'b0;
    checks++;
    if (prog_len !== 5'd0 || cpu_clr !== 1'b1 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_midload got len=%0d cclr=%b rdy=%b want 0 1 1", prog_len, cpu_clr, load_ready);
    end
    send_byte(8'h88, 1'b1);
    address = 4'h0;
    #1;
    checks++;
    if (prog_len !== 5'd1 || memoryOut !== 8'h88) begin
      errors++;
      $display("FAIL clr_next_at0 got len=%0d mem0=%h want 1 88", prog_len, memoryOut);
    end
    for (int a = 1; a < 16; a++) begin
      address = 4'(a);
      #1;
      checks++;
      if (memoryOut !== 8'h00) begin
        errors++;
        $display("FAIL clr_word_cleared addr=%0d got %h want 00", a, memoryOut);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_last();
    test_cpu_write();
    test_wprotect();
    test_full16();
    test_reset();
    test_clr_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
